// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, x/y counters, sync/blank decode,
// line/frame start markers and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COUNT_W   = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    output logic               p_tick,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_DISPLAY);
    localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_DISPLAY);
    localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [COUNT_W-1:0] r_x;
    logic [COUNT_W-1:0] r_y;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_tick;
    logic [DIV_W-1:0]   w_div_next;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic               w_frame_wrap;
    logic [COUNT_W-1:0] w_x_next;
    logic [COUNT_W-1:0] w_y_next;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_video_next;
    logic               w_line_next;
    logic               w_frame_next;

    // p_tick is a one-clk strobe with no back-pressure: on the edge where it is high the
    // pixel state advances, and the decoded outputs move with it.
    assign w_tick = en && (r_div_cnt == DIV_LAST);

    always_comb begin
        w_div_next   = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        w_x_wrap     = (r_x == H_LAST);
        w_y_wrap     = (r_y == V_LAST);
        w_frame_wrap = w_x_wrap && w_y_wrap;
        w_x_next     = w_x_wrap ? '0 : r_x + COUNT_W'(1);
        w_y_next     = r_y;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? '0 : r_y + COUNT_W'(1);
        end
    end

    // Decode the pixel about to be shown so the registered flags line up with it.
    always_comb begin
        w_hs_act     = (w_x_next >= HS_START) && (w_x_next <= HS_END);
        w_vs_act     = (w_y_next >= VS_START) && (w_y_next <= VS_END);
        w_video_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
        w_line_next  = (w_x_next == '0);
        w_frame_next = (w_x_next == '0) && (w_y_next == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_cnt   <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_video_on    <= 1'b1;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else begin
            if (en) begin
                r_div_cnt <= w_div_next;
            end
            if (w_tick) begin
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
                r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
                r_video_on    <= w_video_next;
                r_line_start  <= w_line_next;
                r_frame_start <= w_frame_next;
                if (w_frame_wrap) begin
                    r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    assign p_tick      = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
